// File: rtl/full_substractor_pkg.sv
// Shared constants for the subtractor slice and other arithmetic leaf blocks.
package full_substractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned MAX_WIDTH     = 64;

endpackage

// File: rtl/full_substractor_if.sv
// Operand/result bundle for full_substractor; master drives operands, slave computes.
interface full_substractor_if
  import full_substractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             Bin;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  modport master (
    output a, b, Bin,
    input  diff, borrow, diff_q, borrow_q
  );

  modport slave (
    input  a, b, Bin,
    output diff, borrow, diff_q, borrow_q
  );

endinterface

// File: rtl/full_sub_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout is the borrow to the next bit.
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/full_substractor.sv
// Ripple-borrow subtractor a - b - Bin with combinational and registered results.
module full_substractor
  import full_substractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  full_substractor_if.slave   bus
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_d;
  logic             borrow_q;

  assign br[0] = bus.Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_sub_bit u_bit (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .bin  (br[i]),
      .d    (d[i]),
      .bout (br[i+1])
    );
  end

  always_comb begin
    diff_d   = d;
    borrow_d = br[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.diff     = d;
  assign bus.borrow   = br[WIDTH];
  assign bus.diff_q   = diff_q;
  assign bus.borrow_q = borrow_q;

endmodule

// File: tb/tb_full_substractor.sv
// Directed and random checks of full_substractor at WIDTH=1 and WIDTH=8.
module tb_full_substractor;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  full_substractor_if #(.WIDTH(1)) if1 ();
  full_substractor_if #(.WIDTH(8)) if8 ();

  full_substractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  full_substractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboards hold {borrow,diff} expected on the registered outputs after the next edge.
  logic [1:0] sb1[$];
  logic [8:0] sb8[$];
  logic [1:0] last1;
  logic [8:0] last8;
  logic [1:0] tt[8];

  function automatic logic [1:0] ref1(input logic a, input logic b, input logic bin);
    logic [1:0] r;
    r = {1'b0, a} - {1'b0, b} - {1'b0, bin};
    return r;
  endfunction

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] r;
    r = {1'b0, a} - {1'b0, b} - {8'h00, bin};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic a1, input logic b1, input logic bin1,
                      input logic [7:0] a8, input logic [7:0] b8, input logic bin8);
    logic [1:0] e1;
    logic [8:0] e8;
    @(negedge clk);
    if1.a = a1;  if1.b = b1;  if1.Bin = bin1;
    if8.a = a8;  if8.b = b8;  if8.Bin = bin8;
    e1 = ref1(a1, b1, bin1);
    e8 = ref8(a8, b8, bin8);
    sb1.push_back(e1);
    sb8.push_back(e8);
    #1;
    chk("comb1", 9'({if1.borrow, if1.diff}), 9'(e1));
    chk("comb8", {if8.borrow, if8.diff}, e8);
    chk("hold1", 9'({if1.borrow_q, if1.diff_q}), 9'(last1));
    chk("hold8", {if8.borrow_q, if8.diff_q}, last8);
    @(posedge clk);
    #1;
    last1 = sb1.pop_front();
    last8 = sb8.pop_front();
    chk("reg1", 9'({if1.borrow_q, if1.diff_q}), 9'(last1));
    chk("reg8", {if8.borrow_q, if8.diff_q}, last8);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    logic [2:0] v;

    total = 0;
    bad   = 0;
    last1 = '0;
    last8 = '0;
    // Indexed by {a,b,Bin}; entries are {diff,borrow}.
    tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

    rst_n  = 1'b0;
    if1.a = 1'b0; if1.b = 1'b0; if1.Bin = 1'b0;
    if8.a = 8'h00; if8.b = 8'h00; if8.Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q1", 9'({if1.borrow_q, if1.diff_q}), 9'h000);
    chk("rst_q8", {if8.borrow_q, if8.diff_q}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive 1-bit truth table, 8-bit side exercises boundaries alongside.
    for (int unsigned i = 0; i < 8; i++) begin
      v = 3'(i);
      step(v[2], v[1], v[0], {8{v[2]}}, {8{v[1]}}, v[0]);
      chk($sformatf("tt%0d", i), 9'({if1.diff, if1.borrow}), 9'(tt[i]));
    end

    // Latency: 0 captured first, then 1-0-0 must appear only after the following edge.
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h80, 8'h01, 1'b0);
    chk("lat1", 9'({if1.borrow_q, if1.diff_q}), 9'h001);
    chk("mid8", {if8.borrow_q, if8.diff_q}, 9'h07F);

    // Boundaries on the 8-bit instance.
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
    chk("uf8", {if8.borrow, if8.diff}, 9'h100);
    step(1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A, 1'b0);
    chk("eq0_8", {if8.borrow, if8.diff}, 9'h000);
    step(1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1);
    chk("eq1_8", {if8.borrow, if8.diff}, 9'h1FF);

    // Reset asserted while registers hold 1/1; combinational path keeps tracking.
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q1", 9'({if1.borrow_q, if1.diff_q}), 9'h000);
    chk("arst_q8", {if8.borrow_q, if8.diff_q}, 9'h000);
    chk("arst_c1", 9'({if1.borrow, if1.diff}), 9'h003);
    chk("arst_c8", {if8.borrow, if8.diff}, 9'h1FF);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_q1", 9'({if1.borrow_q, if1.diff_q}), 9'h000);
    @(posedge clk);
    #1;
    chk("rel_cap1", 9'({if1.borrow_q, if1.diff_q}), 9'h003);
    chk("rel_cap8", {if8.borrow_q, if8.diff_q}, 9'h1FF);
    last1 = 2'b11;
    last8 = 9'h1FF;

    for (int unsigned n = 0; n < 1000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      step(ra[0], rb[0], rbin, ra, rb, rbin);
    end

    // Short reset pulse between edges with random operands held.
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_q8", {if8.borrow_q, if8.diff_q}, 9'h000);
    chk("pulse_c8", {if8.borrow, if8.diff}, last8);
    chk("pulse_c1", 9'({if1.borrow, if1.diff}), 9'(last1));
    #1 rst_n = 1'b1;
    last1 = '0;
    last8 = '0;
    step(1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 1'b1);

    chk("sb_empty", 9'(sb8.size() + sb1.size()), 9'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
